qupls4_regfile_lvt_nwnr: RTL

- Parametrised multi-port physical register file for the Qupls4 back end.
- NWR write ports and NRD read ports built from live-value-table (LVT) banked RAMs: one bank per write port, replicated per read port.
- Over the previous 4-write generation it adds:
  - a parametric write-port count;
  - a per-byte-lane LVT, so partial (byte-enabled) writes from different ports merge correctly;
  - a registered one-cycle read with same-cycle write forwarding;
  - a post-reset clear sequencer.

---
 rtl/qupls4_regfile_lvt_nwnr.sv | 126 ++++++++++++
 1 files changed

// File: rtl/qupls4_regfile_lvt_nwnr.sv
// qupls4_regfile_lvt_nwnr: multi-port LVT register file with per-lane LVT, write-first forwarding and clear sequencer.
// Optional per-lane even parity via QUPLS4_RF_PARITY_EN.
module qupls4_regfile_lvt_nwnr #(
  parameter int NWR  = 4,
  parameter int NRD  = 12,
  parameter int VWID = 64,
  parameter int FWID = 8,
  parameter int DEP  = 512,
  parameter int BWW  = 8,
  parameter int AW   = $clog2(DEP)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NWR-1:0]                      wr,
  input  logic [NWR*((VWID+FWID)/BWW)-1:0]    we,
  input  logic [NWR*AW-1:0]                   wa,
  input  logic [NWR*(VWID+FWID)-1:0]          wd,
  input  logic [NRD*AW-1:0]                   ra,
  output logic [NRD*VWID-1:0]                 o,
  output logic [NRD*FWID-1:0]                 to,
  output logic                                rdy,
  output logic [NRD-1:0]                      perr
);
  localparam int W  = VWID + FWID;
  localparam int NB = W / BWW;
  localparam int LW = NWR > 1 ? $clog2(NWR) : 1;
  typedef enum logic {INIT, RUN} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [W-1:0] rd_q [NRD];
  logic [W-1:0] rd_d [NRD];
  logic [NRD-1:0] perr_q, perr_d;
  logic run;
  logic [W-1:0] bank_mem [NWR][DEP];
  logic [NB*LW-1:0] lvt_mem [DEP];
`ifdef QUPLS4_RF_PARITY_EN
  logic [NB-1:0] par_mem [NWR][DEP];
`endif
  assign run = state_q == RUN;
  assign rdy = run;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    if (!run) begin
      cnt_d = cnt_q == AW'(DEP - 1) ? cnt_q : cnt_q + 1'b1;
      state_d = cnt_q == AW'(DEP - 1) ? RUN : INIT;
    end
  end
  // Each lane picks its bank through the LVT, then a same-cycle write (highest port last) overrides it.
  always_comb begin
    logic [AW-1:0] a;
    logic [NB*LW-1:0] e;
    logic [LW-1:0] s;
    logic [BWW-1:0] l;
    logic f;
    a = '0;
    e = '0;
    s = '0;
    l = '0;
    f = 1'b0;
    perr_d = '0;
    for (int g = 0; g < NRD; g++) begin
      rd_d[g] = '0;
      a = ra[g*AW +: AW];
      e = lvt_mem[a];
      for (int b = 0; b < NB; b++) begin
        s = e[b*LW +: LW];
        l = bank_mem[s][a][b*BWW +: BWW];
        f = 1'b0;
        for (int p = 0; p < NWR; p++)
          if (wr[p] && we[p*NB+b] && wa[p*AW +: AW] == a) begin
            l = wd[p*W + b*BWW +: BWW];
            f = 1'b1;
          end
        rd_d[g][b*BWW +: BWW] = l;
`ifdef QUPLS4_RF_PARITY_EN
        if (!f && ((^bank_mem[s][a][b*BWW +: BWW]) != par_mem[s][a][b]))
          perr_d[g] = 1'b1;
`endif
      end
      if (!run || a == '0) begin
        rd_d[g] = '0;
        perr_d[g] = 1'b0;
      end
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= INIT;
      cnt_q <= '0;
      rd_q <= '{default: '0};
      perr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rd_q <= rd_d;
      perr_q <= perr_d;
    end
  // Banks need no reset: the INIT sweep clears every entry before writes are accepted.
  always_ff @(posedge clk)
    if (!run) begin
      lvt_mem[cnt_q] <= '0;
      for (int p = 0; p < NWR; p++) begin
        bank_mem[p][cnt_q] <= '0;
`ifdef QUPLS4_RF_PARITY_EN
        par_mem[p][cnt_q] <= '0;
`endif
      end
    end else
      for (int p = 0; p < NWR; p++)
        if (wr[p])
          for (int b = 0; b < NB; b++)
            if (we[p*NB+b]) begin
              bank_mem[p][wa[p*AW +: AW]][b*BWW +: BWW] <= wd[p*W + b*BWW +: BWW];
              lvt_mem[wa[p*AW +: AW]][b*LW +: LW] <= LW'(p);
`ifdef QUPLS4_RF_PARITY_EN
              par_mem[p][wa[p*AW +: AW]][b] <= ^wd[p*W + b*BWW +: BWW];
`endif
            end
  always_comb
    for (int g = 0; g < NRD; g++) begin
      o[g*VWID +: VWID] = rd_q[g][VWID-1:0];
      to[g*FWID +: FWID] = rd_q[g][W-1:VWID];
    end
  assign perr = perr_q;
endmodule
